// File: rtl/ts_seq_pkg.sv
// ============================================================================
// Module   : ts_seq_pkg
// Brief    : Shared types and constants for the sound-core bus sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ts_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_READ   = 3'd5
  } seq_state_e;

  localparam logic [4:0] SEL_CMD_PREFIX = 5'b11111;
  localparam logic [7:0] FM_REG_BASE    = 8'h10;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } wr_entry_t;

  function automatic logic is_sel_cmd(input wr_entry_t e);
    return e.port && (e.data[7:3] == SEL_CMD_PREFIX);
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ts_seq_fifo.sv
// ============================================================================
// Module   : ts_seq_fifo
// Brief    : Synchronous count-based first-word-fall-through FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ts_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q;
  logic [c_aw-1:0]  rd_ptr_q;
  logic [c_aw:0]    count_q;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (count_q == (c_aw+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // Full is judged before any same-cycle pop, so a push into a full FIFO is dropped.
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_aw'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_aw'(1);
      count_q <= count_q + {{c_aw{1'b0}}, w_push} - {{c_aw{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/ts_bus_sequencer.sv
// ============================================================================
// Module   : ts_bus_sequencer
// Brief    : Serialises CPU port writes/reads onto the YM2203-style BDIR/BC bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ts_bus_sequencer
  import ts_seq_pkg::*;
#(
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2,
  parameter int FM_WAIT_CE = 24,
  parameter int RD_CYC     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic       wr_req,
  input  logic       wr_port,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       rd_req,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] DO,
  input  logic [7:0] DI
);

  localparam int c_cnt_w = $clog2(max4(STROBE_CYC, HOLD_CYC, FM_WAIT_CE, RD_CYC) + 1);

  seq_state_e         state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               is_fm_q, is_fm_d;
  logic               fm_en_q, fm_en_d;
  logic [7:0]         cur_reg_q, cur_reg_d;
  logic               rd_pend_q, rd_pend_d;
  logic               bdir_q, bdir_d;
  logic               bc_q, bc_d;
  logic [7:0]         do_q, do_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  wr_entry_t          w_head;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;

  assign w_pop = (state_q == ST_IDLE) && !w_empty;

  ts_seq_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(wr_entry_t))
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .push_i  (wr_req),
    .pop_i   (w_pop),
    .data_i  ({wr_port, wr_data}),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      is_fm_q    <= 1'b0;
      fm_en_q    <= 1'b0;
      cur_reg_q  <= 8'h00;
      rd_pend_q  <= 1'b0;
      bdir_q     <= 1'b0;
      bc_q       <= 1'b0;
      do_q       <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_fm_q    <= is_fm_d;
      fm_en_q    <= fm_en_d;
      cur_reg_q  <= cur_reg_d;
      rd_pend_q  <= rd_pend_d;
      bdir_q     <= bdir_d;
      bc_q       <= bc_d;
      do_q       <= do_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_fm_d   = is_fm_q;
    fm_en_d   = fm_en_q;
    cur_reg_d = cur_reg_q;
    rd_pend_d = rd_pend_q;

    if (rd_req && !rd_pend_q && (state_q != ST_READ)) rd_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!w_empty) begin
          state_d = ST_SETUP;
          // FM-ness uses the shadows as they stand before this entry updates them.
          is_fm_d = !w_head.port && fm_en_q && (cur_reg_q >= FM_REG_BASE);
          if (is_sel_cmd(w_head))  fm_en_d   = ~w_head.data[2];
          else if (w_head.port)    cur_reg_d = w_head.data;
        end else if (rd_pend_q) begin
          state_d   = ST_READ;
          rd_pend_d = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = '0;
      end
      ST_STROBE: begin
        if (cnt_q == c_cnt_w'(STROBE_CYC - 1)) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == c_cnt_w'(HOLD_CYC - 1)) begin
          state_d = is_fm_q ? ST_WAIT : ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      ST_WAIT: begin
        if (CE) begin
          if (cnt_q == c_cnt_w'(FM_WAIT_CE - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_cnt_w'(1);
          end
        end
      end
      ST_READ: begin
        if (cnt_q == c_cnt_w'(RD_CYC - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bus outputs are derived from the next state so the registers line up with the state.
  always_comb begin
    bdir_d     = (state_d == ST_STROBE);
    bc_d       = bc_q;
    do_d       = do_q;
    rd_valid_d = (state_q == ST_READ) && (state_d == ST_IDLE);
    rd_data_d  = rd_valid_d ? DI : rd_data_q;
    if ((state_q == ST_IDLE) && (state_d == ST_SETUP)) begin
      bc_d = w_head.port;
      do_d = w_head.data;
    end
    if (state_d == ST_READ) bc_d = 1'b0;
  end

  assign wr_ready = !w_full;
  assign busy     = (state_q != ST_IDLE) || !w_empty || rd_pend_q;
  assign BDIR     = bdir_q;
  assign BC       = bc_q;
  assign DO       = do_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_ts_bus_sequencer.sv
// ============================================================================
// Module   : tb_ts_bus_sequencer
// Brief    : Scoreboard bench for ts_bus_sequencer bus writes, waits and reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ts_bus_sequencer;

  localparam int STROBE_CYC = 4;
  localparam int HOLD_CYC   = 2;
  localparam int FM_WAIT_CE = 24;
  localparam int RD_CYC     = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CE = 1'b0;
  logic       wr_req = 1'b0;
  logic       wr_port = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       rd_req = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       BDIR;
  logic       BC;
  logic [7:0] DO;
  logic [7:0] DI = 8'h00;

  ts_bus_sequencer dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .CE       (CE),
    .wr_req   (wr_req),
    .wr_port  (wr_port),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .BDIR     (BDIR),
    .BC       (BC),
    .DO       (DO),
    .DI       (DI)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       port;
    logic [7:0] data;
    bit         wt;
  } exp_t;

  exp_t wq[$];
  int   exp_reads = 0;
  int   got_reads = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // CE every third cycle; DI changes every cycle so only the capture cycle's value matches.
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge CLK);
      #2;
      k++;
      CE = (k % 3 == 0);
      DI = 8'((k * 37 + 5) & 255);
    end
  end

  // Monitor state
  int         mst = 0;
  int         slen = 0;
  int         c = 0;
  bit         stab_ok = 1'b1;
  exp_t       cur;
  bit         ce_hist [256];
  logic       bprev = 1'b0;
  logic       rv_prev = 1'b0;
  logic [7:0] di_prev = 8'h00;

  task automatic close_win(input int L);
    int wc;
    int n;
    wc = L - HOLD_CYC;
    n  = 0;
    for (int i = HOLD_CYC; i < L; i++) n += int'(ce_hist[i]);
    check("bc_do_stable", 32'(stab_ok), 1);
    if (cur.wt) begin
      check("wait_ce_count", n, FM_WAIT_CE);
      check("wait_last_ce", (wc > 0) ? 32'(ce_hist[L-1]) : 32'd0, 1);
    end else begin
      check("no_wait", wc, 0);
    end
    mst = 0;
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (RESET) begin
        mst = 0;
        bprev = BDIR;
        rv_prev = 1'b0;
        di_prev = DI;
        continue;
      end
      if (rd_valid) begin
        got_reads++;
        check("rd_data", rd_data, di_prev);
        check("rd_after_writes", wq.size(), 0);
        check("rd_valid_pulse", rv_prev, 0);
      end
      if (mst == 2) begin
        if (BDIR && !bprev)  close_win(c - 2);
        else if (rd_valid)   close_win(c - RD_CYC - 1);
        else if (!busy)      close_win(c);
        else begin
          if (c < HOLD_CYC) stab_ok &= (BC === cur.port) && (DO === cur.data);
          if (c < 256) ce_hist[c] = CE;
          c++;
        end
      end
      if (mst == 0 && BDIR && !bprev) begin
        if (wq.size() == 0) begin
          check("unexpected_strobe", wq.size(), 1);
          cur = '{BC, DO, 1'b0};
        end else begin
          cur = wq.pop_front();
          check("bc", BC, cur.port);
          check("do", DO, cur.data);
        end
        mst = 1;
        slen = 1;
        stab_ok = 1'b1;
      end else if (mst == 1) begin
        if (BDIR) begin
          slen++;
          stab_ok &= (BC === cur.port) && (DO === cur.data);
        end else begin
          check("strobe_len", slen, STROBE_CYC);
          stab_ok &= (BC === cur.port) && (DO === cur.data);
          ce_hist[0] = CE;
          c = 1;
          mst = 2;
        end
      end
      bprev = BDIR;
      rv_prev = rd_valid;
      di_prev = DI;
    end
  end

  // Stimulus tasks start and end just after a rising edge.
  task automatic push(input logic p, input logic [7:0] d, input logic rdy, input bit wt);
    wr_req = 1'b1;
    wr_port = p;
    wr_data = d;
    @(negedge CLK);
    check("wr_ready", wr_ready, rdy);
    if (rdy) wq.push_back('{p, d, wt});
    @(posedge CLK);
    #1 wr_req = 1'b0;
  endtask

  task automatic rd_pulse();
    rd_req = 1'b1;
    @(posedge CLK);
    #1 rd_req = 1'b0;
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    @(negedge CLK);
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("idle_timeout", 32'(n < 2000), 1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("rst_bdir", BDIR, 0);
    check("rst_bc", BC, 0);
    check("rst_do", DO, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 1);
    @(posedge CLK);
    #1;

    // Two plain writes, fm_en=0
    push(1'b1, 8'h07, 1'b1, 1'b0);
    push(1'b0, 8'h38, 1'b1, 1'b0);
    idle_wait();

    // Six back-to-back: fifth fills the FIFO, sixth dropped
    push(1'b0, 8'hA1, 1'b1, 1'b0);
    push(1'b0, 8'hA2, 1'b1, 1'b0);
    push(1'b0, 8'hA3, 1'b1, 1'b0);
    push(1'b0, 8'hA4, 1'b1, 1'b0);
    push(1'b0, 8'hA5, 1'b1, 1'b0);
    push(1'b0, 8'hA6, 1'b0, 1'b0);
    idle_wait();

    // Read queued behind two writes; second rd_req ignored while pending
    push(1'b0, 8'h11, 1'b1, 1'b0);
    push(1'b0, 8'h22, 1'b1, 1'b0);
    rd_pulse();
    rd_pulse();
    exp_reads++;
    idle_wait();

    // Stand-alone read
    rd_pulse();
    exp_reads++;
    idle_wait();

    // FM enable, register 0x28, FM data write -> WAIT
    push(1'b1, 8'hF8, 1'b1, 1'b0);
    push(1'b1, 8'h28, 1'b1, 1'b0);
    push(1'b0, 8'hF0, 1'b1, 1'b1);
    idle_wait();

    // Select with data[2]=1 disables FM waits
    push(1'b1, 8'hFC, 1'b1, 1'b0);
    push(1'b1, 8'h30, 1'b1, 1'b0);
    push(1'b0, 8'h11, 1'b1, 1'b0);
    idle_wait();

    // cur_reg boundary 0x0F / 0x10; select must not touch cur_reg
    push(1'b1, 8'hF8, 1'b1, 1'b0);
    push(1'b1, 8'h0F, 1'b1, 1'b0);
    push(1'b0, 8'hAA, 1'b1, 1'b0);
    idle_wait();
    push(1'b1, 8'hF8, 1'b1, 1'b0);
    push(1'b0, 8'h42, 1'b1, 1'b0);
    idle_wait();
    push(1'b1, 8'h10, 1'b1, 1'b0);
    push(1'b0, 8'hBB, 1'b1, 1'b1);
    idle_wait();

    // Reset in the second STROBE cycle of an FM write
    push(1'b0, 8'h77, 1'b1, 1'b1);
    n = 0;
    while (BDIR !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("strobe_seen", 32'(n < 50), 1);
    @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("abort_bdir", BDIR, 0);
    check("abort_busy", busy, 0);
    check("abort_wr_ready", wr_ready, 1);
    @(posedge CLK);
    #1;

    // After reset fm_en=0 and cur_reg=0: neither write waits
    push(1'b0, 8'h66, 1'b1, 1'b0);
    idle_wait();
    push(1'b1, 8'hF8, 1'b1, 1'b0);
    push(1'b0, 8'h67, 1'b1, 1'b0);
    idle_wait();

    repeat (3) @(posedge CLK);
    check("read_count", got_reads, exp_reads);
    check("queue_empty", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
